chrom_serial_loader: RTL and testbench

Serial front end for the chromosome processing state machine. Assembles a 992-bit chromosome description from a byte stream and launches one evaluation through the processor's start/done handshake. Captures the eight 32-bit error sums and streams them back as a byte response. Sits between the UART byte interface and the processing state machine's `iConcatedChromDescription` / `iStartProcessing` / `iDoneProcessingFeedback` ports.

---
 rtl/chrom_loader_pkg.sv | 20 ++
 rtl/chrom_byte_tx_serializer.sv | 92 +++++++++
 rtl/chrom_serial_loader.sv | 170 +++++++++++++++++
 tb/tb_chrom_serial_loader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chrom_loader_pkg.sv
// Shared types and constants for the chromosome serial loader and its response serializer.
package chrom_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_READY,
        ST_START,
        ST_WAIT_DONE,
        ST_SEND_HDR,
        ST_SEND_DATA
    } state_t;

    localparam logic [7:0] HDR_CMD  = 8'hA5;
    localparam logic [7:0] HDR_RESP = 8'h5A;
    localparam logic [7:0] HDR_ERR  = 8'hEE;

    localparam int CHROM_BITS = 992;

endpackage

// File: rtl/chrom_byte_tx_serializer.sv
// Response serializer: header byte, then the error-sum snapshot LSB byte first, with valid/ready hold.
// CHROM_LOADER_CHECKSUM_EN appends an XOR byte over the data bytes.
module chrom_byte_tx_serializer
    import chrom_loader_pkg::*;
#(
    parameter int NUM_ERR_WORDS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_resp,
    input  logic                        load_err,
    input  logic [NUM_ERR_WORDS*32-1:0] sums,
    input  logic                        tx_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    output logic                        done
);
    localparam int DATA_BYTES = 4 * NUM_ERR_WORDS;
`ifdef CHROM_LOADER_CHECKSUM_EN
    localparam int LAST_IDX = DATA_BYTES + 1;
`else
    localparam int LAST_IDX = DATA_BYTES;
`endif
    localparam int IDX_W = $clog2(LAST_IDX + 2);

    logic [DATA_BYTES*8-1:0] snap;
    logic [DATA_BYTES*8-1:0] shifted;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        next_idx;
    logic [IDX_W-1:0]        data_sel;
    logic [7:0]              next_byte;
    logic                    single;
    logic                    accept;
    logic                    last;

    assign accept   = tx_valid && tx_ready;
    assign last     = single || (idx == IDX_W'(LAST_IDX));
    assign done     = accept && last;
    assign next_idx = idx + IDX_W'(1);
    assign data_sel = next_idx - IDX_W'(1);

`ifdef CHROM_LOADER_CHECKSUM_EN
    logic [7:0] snap_xor;

    always_comb begin
        snap_xor = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            snap_xor = snap_xor ^ snap[8*i +: 8];
        end
    end
`endif

    // Index 0 is the header, so data byte n-1 goes out at index n.
    always_comb begin
        shifted   = snap >> {data_sel, 3'b000};
        next_byte = shifted[7:0];
`ifdef CHROM_LOADER_CHECKSUM_EN
        if (int'(next_idx) > DATA_BYTES) begin
            next_byte = snap_xor;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
            idx      <= '0;
            single   <= 1'b0;
            snap     <= '0;
        end else if (load_resp) begin
            snap     <= sums;
            tx_data  <= HDR_RESP;
            tx_valid <= 1'b1;
            idx      <= '0;
            single   <= 1'b0;
        end else if (load_err) begin
            tx_data  <= HDR_ERR;
            tx_valid <= 1'b1;
            idx      <= '0;
            single   <= 1'b1;
        end else if (accept) begin
            if (last) begin
                tx_valid <= 1'b0;
            end else begin
                tx_data <= next_byte;
                idx     <= next_idx;
            end
        end
    end

endmodule

// File: rtl/chrom_serial_loader.sv
// Byte-stream front end: assembles a chromosome description, runs one evaluation, returns the error sums.
// CHROM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to the command and to the response.
module chrom_serial_loader
    import chrom_loader_pkg::*;
#(
    parameter int CHROM_BYTES   = CHROM_BITS / 8,
    parameter int NUM_ERR_WORDS = 8,
    parameter int BYTE_TIMEOUT  = 50000
) (
    input  logic                          iClock,
    input  logic                          iReset_n,
    input  logic [7:0]                    iRxData,
    input  logic                          iRxValid,
    output logic [7:0]                    oTxData,
    output logic                          oTxValid,
    input  logic                          iTxReady,
    output logic [CHROM_BYTES*8-1:0]      oConcatedChromDescription,
    output logic                          oStartProcessing,
    input  logic                          iReadyToProcess,
    input  logic                          iDoneProcessing,
    output logic                          oDoneProcessingFeedback,
    input  logic [NUM_ERR_WORDS-1:0][31:0] iErrorSums,
    output logic                          oBusy,
    output logic                          oFrameError
);
    localparam int IDLE_W = $clog2(BYTE_TIMEOUT + 1);
`ifdef CHROM_LOADER_CHECKSUM_EN
    localparam logic [6:0] FINAL_IDX = 7'(CHROM_BYTES);
`else
    localparam logic [6:0] FINAL_IDX = 7'(CHROM_BYTES - 1);
`endif

    state_t                   state;
    state_t                   next_state;
    logic [6:0]               byte_cnt;
    logic [IDLE_W-1:0]        idle_cnt;
    logic [CHROM_BYTES*8-1:0] desc;
    logic                     rx_hdr;
    logic                     frame_err;
    logic                     frame_err_q;
    logic                     done_fb;
    logic                     load_resp;
    logic                     load_err;
    logic                     tx_done;
`ifdef CHROM_LOADER_CHECKSUM_EN
    logic [7:0]               rx_xor;
`endif

    assign rx_hdr = iRxValid && (iRxData == HDR_CMD);

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        frame_err  = 1'b0;
        load_resp  = 1'b0;
        load_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_hdr) next_state = ST_LOAD;
            end
            // A byte arriving on the expiry cycle takes priority over the timeout.
            ST_LOAD: begin
                if (iRxValid) begin
                    if (byte_cnt == FINAL_IDX) begin
`ifdef CHROM_LOADER_CHECKSUM_EN
                        if (iRxData == rx_xor) begin
                            next_state = ST_WAIT_READY;
                        end else begin
                            frame_err  = 1'b1;
                            load_err   = 1'b1;
                            next_state = ST_SEND_DATA;
                        end
`else
                        next_state = ST_WAIT_READY;
`endif
                    end
                end else if (idle_cnt == IDLE_W'(BYTE_TIMEOUT)) begin
                    frame_err  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_WAIT_READY: begin
                if (iReadyToProcess) next_state = ST_START;
            end
            ST_START: begin
                next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (iDoneProcessing) begin
                    load_resp  = 1'b1;
                    next_state = ST_SEND_HDR;
                end
            end
            ST_SEND_HDR: begin
                if (oTxValid && iTxReady) next_state = ST_SEND_DATA;
            end
            ST_SEND_DATA: begin
                if (tx_done) next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (iRxValid && (state != ST_IDLE) && (state != ST_LOAD)) frame_err = 1'b1;
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            desc        <= '0;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            frame_err_q <= 1'b0;
            done_fb     <= 1'b0;
`ifdef CHROM_LOADER_CHECKSUM_EN
            rx_xor      <= '0;
`endif
        end else begin
            frame_err_q <= frame_err;
            done_fb     <= load_resp;
            if ((state == ST_IDLE) && rx_hdr) begin
                byte_cnt <= '0;
                idle_cnt <= '0;
`ifdef CHROM_LOADER_CHECKSUM_EN
                rx_xor   <= '0;
`endif
            end else if (state == ST_LOAD) begin
                if (iRxValid) begin
                    idle_cnt <= '0;
                    for (int k = 0; k < CHROM_BYTES; k++) begin
                        if (byte_cnt == 7'(k)) desc[8*k +: 8] <= iRxData;
                    end
`ifdef CHROM_LOADER_CHECKSUM_EN
                    if (int'(byte_cnt) < CHROM_BYTES) rx_xor <= rx_xor ^ iRxData;
`endif
                    if (byte_cnt != 7'h7F) byte_cnt <= byte_cnt + 7'd1;
                end else if (idle_cnt != IDLE_W'(BYTE_TIMEOUT)) begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end
        end
    end

    chrom_byte_tx_serializer #(
        .NUM_ERR_WORDS(NUM_ERR_WORDS)
    ) u_tx (
        .clk      (iClock),
        .rst_n    (iReset_n),
        .load_resp(load_resp),
        .load_err (load_err),
        .sums     (iErrorSums),
        .tx_ready (iTxReady),
        .tx_data  (oTxData),
        .tx_valid (oTxValid),
        .done     (tx_done)
    );

    assign oConcatedChromDescription = desc;
    assign oStartProcessing          = (state == ST_START);
    assign oDoneProcessingFeedback   = done_fb;
    assign oBusy                     = (state != ST_IDLE);
    assign oFrameError               = frame_err_q;

endmodule

// File: tb/tb_chrom_serial_loader.sv
// Scoreboard bench for chrom_serial_loader; follows CHROM_LOADER_CHECKSUM_EN when it is defined.
module tb_chrom_serial_loader;
    localparam int CHROM_BYTES   = 124;
    localparam int NUM_ERR_WORDS = 8;
    localparam int BYTE_TIMEOUT  = 40;
`ifdef CHROM_LOADER_CHECKSUM_EN
    localparam int RESP_BYTES = 34;
`else
    localparam int RESP_BYTES = 33;
`endif

    logic                           iClock = 1'b0;
    logic                           iReset_n = 1'b0;
    logic [7:0]                     iRxData = '0;
    logic                           iRxValid = 1'b0;
    logic [7:0]                     oTxData;
    logic                           oTxValid;
    logic                           iTxReady = 1'b0;
    logic [CHROM_BYTES*8-1:0]       oConcatedChromDescription;
    logic                           oStartProcessing;
    logic                           iReadyToProcess = 1'b0;
    logic                           iDoneProcessing = 1'b0;
    logic                           oDoneProcessingFeedback;
    logic [NUM_ERR_WORDS-1:0][31:0] iErrorSums = '0;
    logic                           oBusy;
    logic                           oFrameError;

    chrom_serial_loader #(
        .CHROM_BYTES  (CHROM_BYTES),
        .NUM_ERR_WORDS(NUM_ERR_WORDS),
        .BYTE_TIMEOUT (BYTE_TIMEOUT)
    ) dut (
        .iClock                   (iClock),
        .iReset_n                 (iReset_n),
        .iRxData                  (iRxData),
        .iRxValid                 (iRxValid),
        .oTxData                  (oTxData),
        .oTxValid                 (oTxValid),
        .iTxReady                 (iTxReady),
        .oConcatedChromDescription(oConcatedChromDescription),
        .oStartProcessing         (oStartProcessing),
        .iReadyToProcess          (iReadyToProcess),
        .iDoneProcessing          (iDoneProcessing),
        .oDoneProcessingFeedback  (oDoneProcessingFeedback),
        .iErrorSums               (iErrorSums),
        .oBusy                    (oBusy),
        .oFrameError              (oFrameError)
    );

    always #5 iClock = ~iClock;

    int cyc = 0;
    always @(posedge iClock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [CHROM_BYTES*8-1:0] exp_desc = '0;

    int start_cnt = 0, start_cyc = 0;
    int fb_cnt = 0, fb_cyc = 0;
    int fe_cnt = 0, fe_cyc = 0;
    int acc_cnt = 0, last_acc_cyc = 0, tx_rise_cyc = 0;
    int strobe_cyc = 0;
    logic hold_pending = 1'b0;
    logic prev_valid = 1'b0;
    logic [7:0] held_data = '0;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_desc(input string name);
        int bad = 0;
        for (int k = 0; k < CHROM_BYTES; k++) begin
            if (oConcatedChromDescription[8*k +: 8] !== exp_desc[8*k +: 8]) bad++;
        end
        check_output(name, 64'(bad), 64'd0);
    endtask

    // Monitor: samples on the falling edge and pops the scoreboard on every accepted byte.
    always @(negedge iClock) begin
        if (iReset_n) begin
            if (oStartProcessing) begin start_cnt++; start_cyc = cyc; end
            if (oDoneProcessingFeedback) begin fb_cnt++; fb_cyc = cyc; end
            if (oFrameError) begin fe_cnt++; fe_cyc = cyc; end
            if (hold_pending) begin
                check_output("tx_hold_valid", 64'(oTxValid), 64'd1);
                check_output("tx_hold_data", 64'(oTxData), 64'(held_data));
            end
            if (oTxValid && !prev_valid) tx_rise_cyc = cyc;
            if (oTxValid && iTxReady) begin
                acc_cnt++;
                last_acc_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL tx_unexpected: got %0h expected no byte", oTxData);
                end else begin
                    check_output("tx_byte", 64'(oTxData), 64'(exp_q.pop_front()));
                end
            end
            hold_pending = oTxValid && !iTxReady;
            held_data    = oTxData;
            prev_valid   = oTxValid;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        iRxData    = b;
        iRxValid   = 1'b1;
        strobe_cyc = cyc;
        @(posedge iClock);
        #1;
        iRxValid = 1'b0;
    endtask

    // Header, payload byte k = seed ^ k, and (checksum build) the XOR byte, optionally corrupted.
    task automatic send_frame(input logic [7:0] seed, input logic corrupt);
        logic [7:0] x = '0;
        send_byte(8'hA5);
        for (int k = 0; k < CHROM_BYTES; k++) begin
            exp_desc[8*k +: 8] = seed ^ 8'(k);
            x = x ^ seed ^ 8'(k);
            send_byte(seed ^ 8'(k));
        end
`ifdef CHROM_LOADER_CHECKSUM_EN
        send_byte(x ^ {7'd0, corrupt});
`else
        if (corrupt) $display("[TB] corrupt checksum requested in a build without checksum");
`endif
    endtask

    task automatic push_response(input logic [NUM_ERR_WORDS-1:0][31:0] sums);
        logic [7:0] x = '0;
        exp_q.push_back(8'h5A);
        for (int w = 0; w < NUM_ERR_WORDS; w++) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(sums[w][8*b +: 8]);
                x = x ^ sums[w][8*b +: 8];
            end
        end
`ifdef CHROM_LOADER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic wait_drained(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!oBusy && exp_q.size() == 0) break;
            @(posedge iClock);
            #1;
        end
    endtask

    task automatic wait_start(input int s0, input int budget);
        for (int i = 0; i < budget && start_cnt == s0; i++) begin
            @(posedge iClock);
            #1;
        end
    endtask

    initial begin
        int s0, f0, e0, a0, ls, done_cyc;
        logic [NUM_ERR_WORDS-1:0][31:0] sums;

        repeat (3) @(posedge iClock);
        #1;
        check_output("rst_tx_valid", 64'(oTxValid), 64'd0);
        check_output("rst_tx_data", 64'(oTxData), 64'd0);
        check_output("rst_start", 64'(oStartProcessing), 64'd0);
        check_output("rst_done_fb", 64'(oDoneProcessingFeedback), 64'd0);
        check_output("rst_busy", 64'(oBusy), 64'd0);
        check_output("rst_frame_err", 64'(oFrameError), 64'd0);
        check_desc("rst_desc");
        iReset_n = 1'b1;
        @(posedge iClock);
        #1;

        // Non-header byte in IDLE is ignored without an error.
        e0 = fe_cnt;
        send_byte(8'h33);
        repeat (2) @(posedge iClock);
        #1;
        check_output("idle_junk_err", 64'(fe_cnt - e0), 64'd0);
        check_output("idle_junk_busy", 64'(oBusy), 64'd0);

        // Full frame with byte k = k and the processor already idle.
        iReadyToProcess = 1'b1;
        s0 = start_cnt;
        send_frame(8'h00, 1'b0);
        ls = strobe_cyc;
        wait_start(s0, 20);
        check_output("start_count", 64'(start_cnt - s0), 64'd1);
        check_output("start_latency", 64'(start_cyc - ls), 64'd2);
        check_desc("desc_ramp");

        for (int w = 0; w < NUM_ERR_WORDS; w++) sums[w] = 32'(w);
        iErrorSums = sums;
        push_response(sums);
        iTxReady = 1'b1;
        repeat (3) @(posedge iClock);
        #1;
        f0 = fb_cnt;
        a0 = acc_cnt;
        done_cyc = cyc;
        iDoneProcessing = 1'b1;
        @(posedge iClock);
        #1;
        iDoneProcessing = 1'b0;
        wait_drained(200);
        check_output("resp1_left", 64'(exp_q.size()), 64'd0);
        check_output("resp1_bytes", 64'(acc_cnt - a0), 64'(RESP_BYTES));
        check_output("fb_count", 64'(fb_cnt - f0), 64'd1);
        check_output("fb_latency", 64'(fb_cyc - done_cyc), 64'd1);
        check_output("hdr_latency", 64'(tx_rise_cyc - done_cyc), 64'd1);
        check_output("resp1_span", 64'(last_acc_cyc - tx_rise_cyc), 64'(RESP_BYTES - 1));
        check_output("single_start", 64'(start_cnt - s0), 64'd1);
        check_output("resp1_idle", 64'(oBusy), 64'd0);

        // Partial frame followed by silence must time out without starting.
        s0 = start_cnt;
        e0 = fe_cnt;
        send_byte(8'hA5);
        for (int k = 0; k < 10; k++) begin
            exp_desc[8*k +: 8] = 8'hC0 + 8'(k);
            send_byte(8'hC0 + 8'(k));
        end
        ls = strobe_cyc;
        for (int i = 0; i < BYTE_TIMEOUT + 20 && fe_cnt == e0; i++) begin
            @(posedge iClock);
            #1;
        end
        check_output("timeout_err", 64'(fe_cnt - e0), 64'd1);
        check_output("timeout_window",
                     64'((fe_cyc - ls >= BYTE_TIMEOUT) && (fe_cyc - ls <= BYTE_TIMEOUT + 3)), 64'd1);
        check_output("timeout_busy", 64'(oBusy), 64'd0);
        check_output("timeout_no_start", 64'(start_cnt - s0), 64'd0);
        check_desc("timeout_partial_desc");

        // Processor busy for 3 cycles, stray byte in WAIT_DONE, ready toggling during the response.
        iReadyToProcess = 1'b0;
        iTxReady = 1'b0;
        s0 = start_cnt;
        send_frame(8'hFF, 1'b0);
        ls = strobe_cyc;
        repeat (3) @(posedge iClock);
        #1;
        iReadyToProcess = 1'b1;
        wait_start(s0, 20);
        check_output("start_delayed", 64'(start_cyc - ls), 64'd5);
        e0 = fe_cnt;
        send_byte(8'h77);
        repeat (2) @(posedge iClock);
        #1;
        check_output("stray_err", 64'(fe_cnt - e0), 64'd1);
        check_output("stray_busy", 64'(oBusy), 64'd1);
        check_desc("stray_desc");

        sums = {32'h0F0F0F0F, 32'h5A5AA5A5, 32'h80000001, 32'h00000000,
                32'hFFFFFFFF, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};
        iErrorSums = sums;
        push_response(sums);
        a0 = acc_cnt;
        f0 = fb_cnt;
        iDoneProcessing = 1'b1;
        @(posedge iClock);
        #1;
        iDoneProcessing = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!oBusy && exp_q.size() == 0) break;
            iTxReady = ~iTxReady;
            @(posedge iClock);
            #1;
        end
        check_output("resp2_left", 64'(exp_q.size()), 64'd0);
        check_output("resp2_bytes", 64'(acc_cnt - a0), 64'(RESP_BYTES));
        check_output("resp2_fb", 64'(fb_cnt - f0), 64'd1);
        check_output("resp2_idle", 64'(oBusy), 64'd0);
        check_desc("resp2_desc");

`ifdef CHROM_LOADER_CHECKSUM_EN
        // Corrupted checksum: one 0xEE byte, no start.
        iTxReady = 1'b1;
        s0 = start_cnt;
        e0 = fe_cnt;
        a0 = acc_cnt;
        exp_q.push_back(8'hEE);
        send_frame(8'h3C, 1'b1);
        wait_drained(100);
        repeat (2) @(posedge iClock);
        #1;
        check_output("bad_sum_no_start", 64'(start_cnt - s0), 64'd0);
        check_output("bad_sum_err", 64'(fe_cnt - e0), 64'd1);
        check_output("bad_sum_bytes", 64'(acc_cnt - a0), 64'd1);
        check_output("bad_sum_idle", 64'(oBusy), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
